regfile_write_queue: RTL and testbench

Writeback buffer between the execute/memory stages and the 32-entry register file's single write port. Accepts register write requests from two producers (ALU path and load path) with valid/ready handshakes, holds them in order in a small FIFO, and drains one entry per cycle onto the register file's WriteEnable/DAddress/DData port. It also exposes a bypass lookup, so pending-but-not-yet-written values can be forwarded to readers on the A and B read addresses.

---
 rtl/regfile_write_queue.sv | 122 ++++++++++++
 tb/tb_regfile_write_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Writeback buffer in front of the register file's single write port.
// Two producers (ALU, load) enqueue {addr, data} into an in-order circular
// FIFO; the head drains onto WriteEnable/DAddress/DData one entry per cycle.
// Pending entries can be forwarded to the A/B readers via the bypass lookup.
module regfile_write_queue #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_BITS-1:0]         alu_addr,
  input  logic [DATA_BITS-1:0]         alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [ADDR_BITS-1:0]         ld_addr,
  input  logic [DATA_BITS-1:0]         ld_data,
  input  logic                         drain_en,
  input  logic                         flush,
  output logic                         WriteEnable,
  output logic [ADDR_BITS-1:0]         DAddress,
  output logic [DATA_BITS-1:0]         DData,
  input  logic [ADDR_BITS-1:0]         AAddress,
  input  logic [ADDR_BITS-1:0]         BAddress,
  output logic                         a_hit,
  output logic                         b_hit,
  output logic [DATA_BITS-1:0]         a_data,
  output logic [DATA_BITS-1:0]         b_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_BITS-1:0] addr_mem [DEPTH];
  logic [DATA_BITS-1:0] data_mem [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        cnt;

  logic                 alu_fire;
  logic                 ld_fire;
  logic [ADDR_BITS-1:0] enq_addr;
  logic [DATA_BITS-1:0] enq_data;
  logic                 push;
  logic                 pop;

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Ready depends only on registered occupancy and ALU priority, never on drain_en.
  assign alu_ready = !full;
  assign ld_ready  = !full && !alu_valid;

  assign alu_fire = alu_valid && alu_ready;
  assign ld_fire  = ld_valid && ld_ready;
  assign enq_addr = alu_fire ? alu_addr : ld_addr;
  assign enq_data = alu_fire ? alu_data : ld_data;

  // Writes to r0 complete the handshake but are discarded.
  assign push = (alu_fire || ld_fire) && (enq_addr != '0) && !flush && !rst;

  assign WriteEnable = !empty && drain_en && !flush && !rst;
  assign pop         = WriteEnable;

  assign DAddress = empty ? '0 : addr_mem[head];
  assign DData    = empty ? '0 : data_mem[head];

  // Pointer and occupancy control; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; data path carries no reset, validity comes from cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= enq_addr;
      data_mem[tail] <= enq_data;
    end
  end

  // Bypass lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    a_hit  = 1'b0;
    a_data = '0;
    b_hit  = 1'b0;
    b_data = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < cnt) begin
        if ((AAddress != '0) && (addr_mem[idx] == AAddress)) begin
          a_hit  = 1'b1;
          a_data = data_mem[idx];
        end
        if ((BAddress != '0) && (addr_mem[idx] == BAddress)) begin
          b_hit  = 1'b1;
          b_data = data_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: a reference queue of pending writes predicts
// every output each cycle; a monitor pops it whenever WriteEnable fires.
module tb_regfile_write_queue;

  localparam int DB    = 32;
  localparam int AB    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid, drain_en, flush;
  logic          alu_ready, ld_ready;
  logic [AB-1:0] alu_addr, ld_addr, AAddress, BAddress, DAddress;
  logic [DB-1:0] alu_data, ld_data, DData, a_data, b_data;
  logic          WriteEnable, a_hit, b_hit, full, empty;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  regfile_write_queue #(.DATA_BITS(DB), .ADDR_BITS(AB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .drain_en(drain_en), .flush(flush),
    .WriteEnable(WriteEnable), .DAddress(DAddress), .DData(DData),
    .AAddress(AAddress), .BAddress(BAddress),
    .a_hit(a_hit), .b_hit(b_hit), .a_data(a_data), .b_data(b_data),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } ent_t;

  typedef struct {
    bit            av;
    logic [AB-1:0] aa;
    logic [DB-1:0] ad;
    bit            lv;
    logic [AB-1:0] la;
    logic [DB-1:0] ld;
    bit            dr;
    bit            fl;
    bit            rs;
    logic [AB-1:0] qa;
    logic [AB-1:0] qb;
  } vec_t;

  // Table rows: ALU request + drain_en, with hand-derived outputs seen in that cycle.
  typedef struct {
    bit            av;
    logic [AB-1:0] aa;
    logic [DB-1:0] ad;
    bit            dr;
    int            ecnt;
    bit            ewe;
    logic [AB-1:0] eda;
    logic [DB-1:0] edd;
  } tv_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit av, logic [AB-1:0] aa, logic [DB-1:0] ad,
                              bit lv, logic [AB-1:0] la, logic [DB-1:0] ld,
                              bit dr, bit fl, bit rs, logic [AB-1:0] qa, logic [AB-1:0] qb);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.lv = lv; v.la = la; v.ld = ld;
    v.dr = dr; v.fl = fl; v.rs = rs;
    v.qa = qa; v.qb = qb;
    return v;
  endfunction

  function automatic void bypass(input logic [AB-1:0] q, output bit hit, output logic [DB-1:0] d);
    hit = 0;
    d   = '0;
    if (q != 0)
      foreach (sb[i])
        if (sb[i].addr == q) begin
          hit = 1;
          d   = sb[i].data;
        end
  endfunction

  // Apply one cycle of stimulus, check all outputs against the reference queue,
  // record any accepted write, then advance past the clock edge.
  task automatic drive(input vec_t v);
    int            n;
    bit            e_full, e_empty, e_we, acc, eh;
    logic [AB-1:0] ea;
    logic [DB-1:0] ed;
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    ld_valid  = v.lv; ld_addr  = v.la; ld_data  = v.ld;
    drain_en  = v.dr; flush    = v.fl; rst      = v.rs;
    AAddress  = v.qa; BAddress = v.qb;
    #1;
    n       = sb.size();
    e_full  = (n == DEPTH);
    e_empty = (n == 0);
    e_we    = !e_empty && v.dr && !v.fl && !v.rs;
    chk("count", count, n);
    chk("full", full, e_full);
    chk("empty", empty, e_empty);
    chk("alu_ready", alu_ready, !e_full);
    chk("ld_ready", ld_ready, !e_full && !v.av);
    chk("WriteEnable", WriteEnable, e_we);
    chk("DAddress", DAddress, e_empty ? 0 : sb[0].addr);
    chk("DData", DData, e_empty ? 0 : sb[0].data);
    bypass(v.qa, eh, ed);
    chk("a_hit", a_hit, eh);
    chk("a_data", a_data, ed);
    bypass(v.qb, eh, ed);
    chk("b_hit", b_hit, eh);
    chk("b_data", b_data, ed);
    acc = 0; ea = '0; ed = '0;
    if (v.av && !e_full) begin
      acc = 1; ea = v.aa; ed = v.ad;
    end else if (v.lv && !v.av && !e_full) begin
      acc = 1; ea = v.la; ed = v.ld;
    end
    if (acc && ea != 0 && !v.fl && !v.rs) sb.push_back('{ea, ed});
    @(posedge clk);
    if (v.fl || v.rs) sb.delete();
    #1;
  endtask

  // Scoreboard consumer: every issued register-file write must match the oldest pending entry.
  always @(negedge clk) begin
    ent_t e;
    if (WriteEnable === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected got addr %0h data %0h expected no write", DAddress, DData);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", DAddress, e.addr);
        chk("wr_data", DData, e.data);
      end
    end
  end

  tv_t tbl[10];

  initial begin
    tbl = '{
      '{1, 5'd1, 32'h11, 0, 0, 0, 5'd0, 32'h0 },
      '{1, 5'd2, 32'h22, 0, 1, 0, 5'd1, 32'h11},
      '{1, 5'd3, 32'h33, 0, 2, 0, 5'd1, 32'h11},
      '{1, 5'd4, 32'h44, 0, 3, 0, 5'd1, 32'h11},
      '{1, 5'd5, 32'h55, 0, 4, 0, 5'd1, 32'h11},
      '{0, 5'd0, 32'h0,  1, 4, 1, 5'd1, 32'h11},
      '{0, 5'd0, 32'h0,  1, 3, 1, 5'd2, 32'h22},
      '{0, 5'd0, 32'h0,  1, 2, 1, 5'd3, 32'h33},
      '{0, 5'd0, 32'h0,  1, 1, 1, 5'd4, 32'h44},
      '{0, 5'd0, 32'h0,  1, 0, 0, 5'd0, 32'h0 }
    };

    alu_valid = 0; alu_addr = '0; alu_data = '0;
    ld_valid  = 0; ld_addr  = '0; ld_data  = '0;
    drain_en  = 0; flush    = 0; rst      = 1;
    AAddress  = '0; BAddress = '0;
    @(posedge clk);
    #1;

    // Reset held with drain requested: outputs stay at reset values.
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5'd3, 5'd4));
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5'd3, 5'd4));

    // Single write with drain enabled.
    drive(mk(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 5'd5, 0));
    chk("single_we", WriteEnable, 1);
    chk("single_da", DAddress, 5);
    chk("single_dd", DData, 32'hDEADBEEF);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("single_empty", empty, 1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Fill to full, reject the 5th, then drain in order.
    foreach (tbl[i]) begin
      alu_valid = tbl[i].av; drain_en = tbl[i].dr;
      #1;
      chk("tbl_count", count, tbl[i].ecnt);
      chk("tbl_we", WriteEnable, tbl[i].ewe);
      chk("tbl_daddr", DAddress, tbl[i].eda);
      chk("tbl_ddata", DData, tbl[i].edd);
      drive(mk(tbl[i].av, tbl[i].aa, tbl[i].ad, 0, 0, 0, tbl[i].dr, 0, 0, 0, 0));
    end

    // ALU beats load; load goes next cycle; r0 write is swallowed.
    drive(mk(1, 5'd7, 32'h70, 1, 5'd8, 32'h80, 0, 0, 0, 0, 0));
    chk("prio_count", count, 1);
    drive(mk(0, 0, 0, 1, 5'd8, 32'h80, 0, 0, 0, 5'd8, 5'd7));
    chk("ld_count", count, 2);
    drive(mk(1, 5'd0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("r0_count", count, 2);
    for (int k = 0; k < 3; k++) drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Youngest match wins on the bypass; address 0 never hits.
    drive(mk(1, 5'd3, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 5'd3, 32'hB, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0));
    chk("byp_a_hit", a_hit, 1);
    chk("byp_a_data", a_data, 32'hB);
    chk("byp_b_hit", b_hit, 0);
    chk("byp_b_data", b_data, 0);

    // Flush with three entries and a concurrent ALU request.
    drive(mk(1, 5'd9, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pre_flush_count", count, 3);
    drive(mk(1, 5'd10, 32'hAA, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("flush_count", count, 0);
    chk("flush_we", WriteEnable, 0);

    // Same again, with reset instead of flush.
    for (int k = 0; k < 3; k++) drive(mk(1, AB'(11 + k), DB'(32'h100 + k), 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pre_rst_count", count, 3);
    drive(mk(1, 5'd14, 32'hEE, 0, 0, 0, 1, 0, 1, 0, 0));
    chk("rst_count", count, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'd14, 5'd11));

    // Random mixed traffic against the reference queue.
    for (int k = 0; k < 400; k++) begin
      drive(mk(bit'($urandom_range(0, 1)), AB'($urandom_range(0, 7)), $urandom,
               bit'($urandom_range(0, 1)), AB'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 31) == 0),
               AB'($urandom_range(0, 7)), AB'($urandom_range(0, 7))));
    end

    // Bounded drain of whatever is left.
    for (int k = 0; k < 2 * DEPTH && sb.size() != 0; k++)
      drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
